pipe_scheduler: RTL and testbench

- Owns the two scrolling pipe obstacles for the game: their X positions, gap heights, respawn and pass/score bookkeeping.
- Each frame tick it advances both pipes left and selects the "current" (not-yet-passed) pipe.
- The current pipe's edges drive X_Edge_Left/Right and Y_Edge_Top/Bottom of the collision checker.
- Both pipes' raw positions go to the VGA renderer, and the score goes to the display.

---
 rtl/pipe_scheduler_if.sv | 39 +++
 rtl/pipe_scheduler.sv | 159 +++++++++++++++
 tb/tb_pipe_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scheduler_if.sv
// Handshake and position bus between the pipe scheduler and its game-side neighbours
// (controller, collision checker, renderer, score display).
interface pipe_scheduler_if;
  localparam int unsigned W = 10;

  logic         Tick;
  logic         Start;
  logic         Lose;
  logic         Ack;
  logic [W-1:0] Bird_X_L;

  logic [W-1:0] X_Edge_Left;
  logic [W-1:0] X_Edge_Right;
  logic [W-1:0] Y_Edge_Top;
  logic [W-1:0] Y_Edge_Bottom;
  logic [W-1:0] Pipe0_X;
  logic [W-1:0] Pipe1_X;
  logic [W-1:0] Pipe0_Gap;
  logic [W-1:0] Pipe1_Gap;
  logic [W-1:0] Score;
  logic [W-1:0] High_Score;
  logic         Q_Idle;
  logic         Q_Run;
  logic         Q_Halt;

  modport master (
    output Tick, Start, Lose, Ack, Bird_X_L,
    input  X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom,
    input  Pipe0_X, Pipe1_X, Pipe0_Gap, Pipe1_Gap,
    input  Score, High_Score, Q_Idle, Q_Run, Q_Halt
  );

  modport slave (
    input  Tick, Start, Lose, Ack, Bird_X_L,
    output X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom,
    output Pipe0_X, Pipe1_X, Pipe0_Gap, Pipe1_Gap,
    output Score, High_Score, Q_Idle, Q_Run, Q_Halt
  );
endinterface

// File: rtl/pipe_scheduler.sv
// Two scrolling pipe obstacles: movement, LFSR-driven respawn gaps, pass detection,
// score/high-score bookkeeping, and the current pipe's edges for collision checking.
module pipe_scheduler #(
  parameter int unsigned X_START   = 640,
  parameter int unsigned SPACING   = 320,
  parameter int unsigned PIPE_W    = 60,
  parameter int unsigned GAP_H     = 120,
  parameter int unsigned GAP_MIN   = 60,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SCORE_MAX = 999,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic           Clk,
  input  logic           reset,
  pipe_scheduler_if.slave bus
);
  localparam int unsigned W = 10;

  localparam logic [W-1:0] X0_RST  = W'(X_START);
  localparam logic [W-1:0] X1_RST  = W'(X_START + SPACING);
  localparam logic [W-1:0] GAP_RST = W'(GAP_MIN + 100);
  localparam logic [W-1:0] PW      = W'(PIPE_W);
  localparam logic [W-1:0] GH      = W'(GAP_H);
  localparam logic [W-1:0] GMIN    = W'(GAP_MIN);
  localparam logic [W-1:0] SPD     = W'(SPEED);
  localparam logic [W-1:0] SMAX    = W'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_HALT = 3'b100
  } state_t;

  state_t       state;
  logic [W-1:0] x0, x1;
  logic [W-1:0] gap0, gap1;
  logic [W-1:0] score, high_score;
  logic         cur;
  logic [7:0]   lfsr;

  logic [W-1:0] x0_nxt_c, x1_nxt_c;
  logic [W-1:0] gap0_nxt_c, gap1_nxt_c;
  logic [W-1:0] gap_spawn_c;
  logic [W-1:0] xcur_nxt_c;
  logic         pass_c;

  // Free-running gap source, never held by the FSM
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Post-move positions; a pipe that would step past zero respawns instead
  always_comb begin
    gap_spawn_c = GMIN + {2'b00, lfsr};

    x0_nxt_c   = x0;
    gap0_nxt_c = gap0;
    if (x0 < SPD) begin
      x0_nxt_c   = X0_RST;
      gap0_nxt_c = gap_spawn_c;
    end else begin
      x0_nxt_c   = x0 - SPD;
    end

    x1_nxt_c   = x1;
    gap1_nxt_c = gap1;
    if (x1 < SPD) begin
      x1_nxt_c   = X0_RST;
      gap1_nxt_c = gap_spawn_c;
    end else begin
      x1_nxt_c   = x1 - SPD;
    end

    xcur_nxt_c = cur ? x1_nxt_c : x0_nxt_c;
    pass_c     = (xcur_nxt_c + PW) < bus.Bird_X_L;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      x0         <= X0_RST;
      x1         <= X1_RST;
      gap0       <= GAP_RST;
      gap1       <= GAP_RST;
      cur        <= 1'b0;
      score      <= '0;
      high_score <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            state <= S_RUN;
            score <= '0;
          end
        end

        S_RUN: begin
          // Lose wins over a coincident Tick: the frame is dropped
          if (bus.Lose) begin
            state <= S_HALT;
            if (score > high_score) begin
              high_score <= score;
            end
          end else if (bus.Tick) begin
            x0   <= x0_nxt_c;
            x1   <= x1_nxt_c;
            gap0 <= gap0_nxt_c;
            gap1 <= gap1_nxt_c;
            if (pass_c) begin
              cur   <= ~cur;
              score <= (score >= SMAX) ? SMAX : score + W'(1);
            end
          end
        end

        S_HALT: begin
          if (bus.Ack) begin
            state <= S_IDLE;
            x0    <= X0_RST;
            x1    <= X1_RST;
            gap0  <= GAP_RST;
            gap1  <= GAP_RST;
            cur   <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          x0    <= X0_RST;
          x1    <= X1_RST;
          gap0  <= GAP_RST;
          gap1  <= GAP_RST;
          cur   <= 1'b0;
        end
      endcase
    end
  end

  // Edge outputs select the current pipe's registers directly
  assign bus.X_Edge_Left   = cur ? x1 : x0;
  assign bus.X_Edge_Right  = (cur ? x1 : x0) + PW;
  assign bus.Y_Edge_Top    = cur ? gap1 : gap0;
  assign bus.Y_Edge_Bottom = (cur ? gap1 : gap0) + GH;

  assign bus.Pipe0_X    = x0;
  assign bus.Pipe1_X    = x1;
  assign bus.Pipe0_Gap  = gap0;
  assign bus.Pipe1_Gap  = gap1;
  assign bus.Score      = score;
  assign bus.High_Score = high_score;

  assign bus.Q_Idle = state[0];
  assign bus.Q_Run  = state[1];
  assign bus.Q_Halt = state[2];
endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: directed table, hand-written corner sequences, and a
// randomized run compared every cycle against a frame-level game model.
module tb_pipe_scheduler;
  localparam int unsigned W = 10;

  logic Clk;
  logic reset;

  pipe_scheduler_if bus();

  pipe_scheduler dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int         m_mode;   // 0 idle, 1 run, 2 halt
  int         m_x[2];
  int         m_gap[2];
  int         m_cur;
  int         m_score;
  int         m_high;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_x[0]  = 640;
    m_x[1]  = 960;
    m_gap[0] = 160;
    m_gap[1] = 160;
    m_cur   = 0;
    m_score = 0;
    m_high  = 0;
    m_lfsr  = 8'hA5;
  endtask

  task automatic model_step();
    logic [7:0] lf;
    lf     = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    case (m_mode)
      0: if (bus.Start) begin
           m_mode  = 1;
           m_score = 0;
         end
      1: if (bus.Lose) begin
           m_mode = 2;
           if (m_score > m_high) m_high = m_score;
         end else if (bus.Tick) begin
           for (int i = 0; i < 2; i++) begin
             if (m_x[i] < 2) begin
               m_x[i]   = 640;
               m_gap[i] = 60 + int'(lf);
             end else begin
               m_x[i] = m_x[i] - 2;
             end
           end
           if (m_x[m_cur] + 60 < int'(bus.Bird_X_L)) begin
             if (m_score < 999) m_score = m_score + 1;
             m_cur = 1 - m_cur;
           end
         end
      default: if (bus.Ack) begin
           m_mode   = 0;
           m_x[0]   = 640;
           m_x[1]   = 960;
           m_gap[0] = 160;
           m_gap[1] = 160;
           m_cur    = 0;
         end
    endcase
  endtask

  always @(posedge Clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  function automatic logic [102:0] model_vec();
    logic [2:0] q;
    q = (m_mode == 0) ? 3'b001 : (m_mode == 1) ? 3'b010 : 3'b100;
    return {q, W'(m_x[m_cur]), W'(m_x[m_cur] + 60), W'(m_gap[m_cur]), W'(m_gap[m_cur] + 120),
            W'(m_x[0]), W'(m_x[1]), W'(m_gap[0]), W'(m_gap[1]), W'(m_score), W'(m_high)};
  endfunction

  function automatic logic [102:0] dut_vec();
    return {bus.Q_Halt, bus.Q_Run, bus.Q_Idle, bus.X_Edge_Left, bus.X_Edge_Right,
            bus.Y_Edge_Top, bus.Y_Edge_Bottom, bus.Pipe0_X, bus.Pipe1_X,
            bus.Pipe0_Gap, bus.Pipe1_Gap, bus.Score, bus.High_Score};
  endfunction

  bit mdl_en = 1'b0;

  always @(negedge Clk) begin
    if (mdl_en) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL model_cmp t=%0t got %h expected %h", $time, dut_vec(), model_vec());
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic       start;
    logic       tick;
    logic       lose;
    logic       ack;
    logic [2:0] q;      // {Halt, Run, Idle}
    int         p0;
    int         p1;
    int         score;
    int         xr;
  } vec_t;

  vec_t tbl[13];

  task automatic clear_inputs();
    bus.Start = 1'b0;
    bus.Tick  = 1'b0;
    bus.Lose  = 1'b0;
    bus.Ack   = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_q_idle"}, int'(bus.Q_Idle), 1);
    chk({tag, "_q_run"},  int'(bus.Q_Run), 0);
    chk({tag, "_xl"},     int'(bus.X_Edge_Left), 640);
    chk({tag, "_xr"},     int'(bus.X_Edge_Right), 700);
    chk({tag, "_yt"},     int'(bus.Y_Edge_Top), 160);
    chk({tag, "_yb"},     int'(bus.Y_Edge_Bottom), 280);
    chk({tag, "_p1x"},    int'(bus.Pipe1_X), 960);
    chk({tag, "_score"},  int'(bus.Score), 0);
    chk({tag, "_high"},   int'(bus.High_Score), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    int pre0, pre1;
    int exp_gap;

    model_reset();
    reset = 1'b1;
    clear_inputs();
    bus.Bird_X_L = 10'd200;
    #12;
    reset = 1'b0;
    step();
    mdl_en = 1'b1;
    check_reset_values("reset");

    //                 st tk lo ak  q       p0   p1  sc  xr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 640, 960, 0, 700};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 640, 960, 0, 700};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 638, 958, 0, 698};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 638, 958, 0, 698};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 636, 956, 0, 696};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 636, 956, 0, 696};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 636, 956, 0, 696};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 636, 956, 0, 696};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 636, 956, 0, 696};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 636, 956, 0, 696};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 640, 960, 0, 700};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 640, 960, 0, 700};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 640, 960, 0, 700};

    foreach (tbl[i]) begin
      bus.Start = tbl[i].start;
      bus.Tick  = tbl[i].tick;
      bus.Lose  = tbl[i].lose;
      bus.Ack   = tbl[i].ack;
      step();
      clear_inputs();
      chk($sformatf("tbl%0d_q", i), int'({bus.Q_Halt, bus.Q_Run, bus.Q_Idle}), int'(tbl[i].q));
      chk($sformatf("tbl%0d_p0", i), int'(bus.Pipe0_X), tbl[i].p0);
      chk($sformatf("tbl%0d_p1", i), int'(bus.Pipe1_X), tbl[i].p1);
      chk($sformatf("tbl%0d_score", i), int'(bus.Score), tbl[i].score);
      chk($sformatf("tbl%0d_xr", i), int'(bus.X_Edge_Right), tbl[i].xr);
    end

    // First pass with the bird at x=200
    pulse_reset();
    step();
    bus.Bird_X_L = 10'd200;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    bus.Tick  = 1'b1;
    for (int i = 0; i < 250; i++) step();
    chk("t250_p0", int'(bus.Pipe0_X), 140);
    chk("t250_score", int'(bus.Score), 0);
    step();
    chk("t251_p0", int'(bus.Pipe0_X), 138);
    chk("t251_score", int'(bus.Score), 1);
    chk("t251_xl", int'(bus.X_Edge_Left), 458);
    chk("t251_xr", int'(bus.X_Edge_Right), 518);

    // Pipe 0 walks to zero, then respawns with an LFSR gap
    for (int i = 0; i < 69; i++) step();
    chk("t320_p0", int'(bus.Pipe0_X), 0);
    exp_gap = 60 + int'(m_lfsr);
    step();
    chk("respawn_p0", int'(bus.Pipe0_X), 640);
    chk("respawn_gap", int'(bus.Pipe0_Gap), exp_gap);
    chk("respawn_p1", int'(bus.Pipe1_X), 318);

    // Play on to a score of 3, then collide on a Tick cycle
    n = 0;
    while (m_score < 3 && n < 1000) begin
      step();
      n++;
    end
    chk("reach_score3_bound", int'(n < 1000), 1);
    chk("score3", int'(bus.Score), 3);
    pre0 = m_x[0];
    pre1 = m_x[1];
    bus.Lose = 1'b1;
    step();
    bus.Lose = 1'b0;
    bus.Tick = 1'b0;
    chk("lose_q_halt", int'(bus.Q_Halt), 1);
    chk("lose_p0_frozen", int'(bus.Pipe0_X), pre0);
    chk("lose_p1_frozen", int'(bus.Pipe1_X), pre1);
    chk("lose_high", int'(bus.High_Score), 3);
    bus.Ack = 1'b1;
    step();
    bus.Ack = 1'b0;
    chk("ack_q_idle", int'(bus.Q_Idle), 1);
    chk("ack_p0", int'(bus.Pipe0_X), 640);
    chk("ack_score_kept", int'(bus.Score), 3);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("restart_score", int'(bus.Score), 0);
    chk("restart_q_run", int'(bus.Q_Run), 1);

    // Far-right bird passes a pipe every Tick: drive score into saturation
    bus.Bird_X_L = 10'd1023;
    bus.Tick = 1'b1;
    for (int i = 0; i < 998; i++) step();
    chk("score_998", int'(bus.Score), 998);
    step();
    chk("score_999", int'(bus.Score), 999);
    for (int i = 0; i < 6; i++) step();
    chk("score_sat", int'(bus.Score), 999);
    chk("sat_high_unchanged", int'(bus.High_Score), 3);

    // Async reset lands between clock edges while Tick is high
    @(posedge Clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    #2;
    reset = 1'b0;
    clear_inputs();

    // Randomized play against the model
    for (int c = 0; c < 20000 && failures < 40; c++) begin
      step();
      if ($urandom_range(0, 4999) == 0) begin
        pulse_reset();
      end
      bus.Tick     = ($urandom_range(0, 1) == 1);
      bus.Start    = ($urandom_range(0, 9) == 0);
      bus.Lose     = ($urandom_range(0, 99) < 2);
      bus.Ack      = ($urandom_range(0, 19) == 0);
      bus.Bird_X_L = W'($urandom_range(1023, 63));
    end
    step();
    clear_inputs();
    step();
    mdl_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
